// File: rtl/stream_counting_sink_pkg.sv
// Shared types, constants and helpers for the stream_counting_sink block.
package stream_counting_sink_pkg;

    typedef enum logic {
        IDLE,
        IN_PACKET
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          MAX_KEEP_W = 64;

    // Counts set bits in the low `width` bits of keep; callers zero-extend narrower vectors.
    function automatic logic [7:0] popcount(input logic [MAX_KEEP_W-1:0] keep, input int width);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if (i < width) n = n + 8'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_channel.sv
// AXI-Stream style channel bundle; the sink connects through the slave modport.
interface stream_channel #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
);
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic                    t_last;
    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
                    input  t_ready);
    modport slave  (input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
                    output t_ready);
endinterface

// File: rtl/stream_lfsr.sv
// Fibonacci LFSR advancing every cycle; only built when STREAM_COUNTING_SINK_THROTTLE_EN is defined.
`ifdef STREAM_COUNTING_SINK_THROTTLE_EN
module stream_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] o_state
);
    logic [WIDTH-1:0] r_state;
    logic             w_feedback;

    assign w_feedback = ^(r_state & TAPS);
    assign o_state    = r_state;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) r_state <= SEED;
        else       r_state <= {r_state[WIDTH-2:0], w_feedback};
    end
endmodule
`endif

// File: rtl/stream_counting_sink.sv
// Terminal stream consumer counting beats, packets and bytes and flagging upstream protocol violations.
// Optional LFSR back-pressure is enabled by defining STREAM_COUNTING_SINK_THROTTLE_EN.
module stream_counting_sink
    import stream_counting_sink_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    stream_channel.slave           master,
    input  logic                   clear,
    input  logic [7:0]             throttle,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] packet_count,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic [COUNT_WIDTH-1:0] last_packet_bytes,
    output logic                   in_packet,
    output logic                   protocol_error
);
    localparam int KEEP_W   = $bits(master.t_keep);
    localparam int FIELDS_W = $bits(master.t_data) + 2 * KEEP_W + 1 + $bits(master.t_id)
                            + $bits(master.t_dest) + $bits(master.t_user);

    state_t                 r_state, w_state_next;
    logic                   r_ready, w_ready_next;
    logic [COUNT_WIDTH-1:0] r_beat, r_pkt, r_bytes, r_lpb, r_acc;
    logic                   r_perr, r_stall;
    logic [FIELDS_W-1:0]    r_fields, w_fields;
    logic                   w_accept;
    logic [COUNT_WIDTH-1:0] w_bytes, w_acc_before, w_pkt_total;

`ifdef STREAM_COUNTING_SINK_THROTTLE_EN
    logic [15:0] w_lfsr;
    wire         w_unused_lfsr_hi = ^w_lfsr[15:8];

    stream_lfsr #(.WIDTH(16), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .o_state (w_lfsr)
    );
    assign w_ready_next = (w_lfsr[7:0] >= throttle);
`else
    wire w_unused_throttle = ^throttle;
    assign w_ready_next = 1'b1;
`endif

    assign w_accept     = master.t_valid && r_ready;
    assign w_bytes      = COUNT_WIDTH'(popcount(MAX_KEEP_W'(master.t_keep), KEEP_W));
    assign w_acc_before = (r_state == IN_PACKET) ? r_acc : '0;
    assign w_pkt_total  = w_acc_before + w_bytes;
    assign w_fields     = {master.t_data, master.t_keep, master.t_strb, master.t_last,
                           master.t_id, master.t_dest, master.t_user};

    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned, which would infer a latch.
        w_state_next = r_state;
        if (w_accept) w_state_next = master.t_last ? IDLE : IN_PACKET;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_beat   <= '0;
            r_pkt    <= '0;
            r_bytes  <= '0;
            r_lpb    <= '0;
            r_acc    <= '0;
            r_perr   <= 1'b0;
            r_stall  <= 1'b0;
            r_fields <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ready  <= w_ready_next;
            // Clear zeroes the base value; a coincident beat still adds its increment.
            r_beat   <= (clear ? '0 : r_beat)  + COUNT_WIDTH'(w_accept);
            r_pkt    <= (clear ? '0 : r_pkt)   + COUNT_WIDTH'(w_accept && master.t_last);
            r_bytes  <= (clear ? '0 : r_bytes) + (w_accept ? w_bytes : '0);
            if (w_accept && master.t_last) r_lpb <= w_pkt_total;
            else if (clear)                r_lpb <= '0;
            if (w_accept) r_acc <= w_pkt_total;
            // A stalled beat must be held stable and valid into the following cycle.
            r_stall  <= master.t_valid && !r_ready;
            r_fields <= w_fields;
            if (r_stall && (!master.t_valid || (w_fields != r_fields))) r_perr <= 1'b1;
        end
    end

    assign master.t_ready    = r_ready;
    assign beat_count        = r_beat;
    assign packet_count      = r_pkt;
    assign byte_count        = r_bytes;
    assign last_packet_bytes = r_lpb;
    assign in_packet         = (r_state == IN_PACKET);
    assign protocol_error    = r_perr;
endmodule

// File: tb/tb_stream_counting_sink.sv
// Self-checking bench for stream_counting_sink: vector table, scoreboard queue and corner-case sequences.
module tb_stream_counting_sink;

    logic        clk = 1'b0;
    logic        rstn, clear;
    logic [7:0]  throttle;
    logic        t_valid, t_last;
    logic [31:0] t_data;
    logic [3:0]  t_keep, t_strb, t_id, t_dest;
    logic        t_user;

    logic [31:0] beat32, pkt32, bytes32, lpb32;
    logic        inp32, perr32;
    logic [3:0]  beat4, pkt4, bytes4, lpb4;
    logic        inp4, perr4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_channel #(.DATA_WIDTH(32)) ch32 ();
    stream_channel #(.DATA_WIDTH(32)) ch4 ();

    assign ch32.t_valid = t_valid;
    assign ch32.t_data  = t_data;
    assign ch32.t_keep  = t_keep;
    assign ch32.t_strb  = t_strb;
    assign ch32.t_last  = t_last;
    assign ch32.t_id    = t_id;
    assign ch32.t_dest  = t_dest;
    assign ch32.t_user  = t_user;
    assign ch4.t_valid  = t_valid;
    assign ch4.t_data   = t_data;
    assign ch4.t_keep   = t_keep;
    assign ch4.t_strb   = t_strb;
    assign ch4.t_last   = t_last;
    assign ch4.t_id     = t_id;
    assign ch4.t_dest   = t_dest;
    assign ch4.t_user   = t_user;

    stream_counting_sink #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .master(ch32), .clear(clear), .throttle(throttle),
        .beat_count(beat32), .packet_count(pkt32), .byte_count(bytes32),
        .last_packet_bytes(lpb32), .in_packet(inp32), .protocol_error(perr32)
    );

    stream_counting_sink #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .master(ch4), .clear(clear), .throttle(throttle),
        .beat_count(beat4), .packet_count(pkt4), .byte_count(bytes4),
        .last_packet_bytes(lpb4), .in_packet(inp4), .protocol_error(perr4)
    );

    typedef struct {
        logic [3:0]  keep;
        logic        last;
        logic        clr;
        logic [31:0] beat, pkt, bytes, lpb;
        logic        inp;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] beat, pkt, bytes, lpb;
        logic        inp;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; t_valid = 1'b0; clear = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
    endtask

    // Drives one beat, queues its expected statistics and compares once the beat is accepted.
    task automatic send(input string tag, input logic [3:0] keep, input logic last, input logic clr,
                        input logic [31:0] e_beat, input logic [31:0] e_pkt,
                        input logic [31:0] e_bytes, input logic [31:0] e_lpb, input logic e_inp);
        exp_t e;
        logic acc;
        acc = 1'b0;
        t_keep = keep; t_strb = keep; t_last = last; t_data = $urandom; clear = clr; t_valid = 1'b1;
        sb.push_back('{tag, e_beat, e_pkt, e_bytes, e_lpb, e_inp});
        for (int n = 0; n < 200; n++) begin
            acc = ch32.t_ready;
            step();
            if (acc) break;
        end
        t_valid = 1'b0; clear = 1'b0;
        e = sb.pop_front();
        check({e.tag, ".accepted"}, 32'(acc), 32'd1);
        check({e.tag, ".beat"},  beat32,  e.beat);
        check({e.tag, ".pkt"},   pkt32,   e.pkt);
        check({e.tag, ".bytes"}, bytes32, e.bytes);
        check({e.tag, ".lpb"},   lpb32,   e.lpb);
        check({e.tag, ".inp"},   32'(inp32), 32'(e.inp));
    endtask

    int ones;
    logic rec1 [1000];
    logic rec2 [1000];
    int diffs;

    initial begin
        vecs[0] = '{4'hF, 1'b0, 1'b0, 32'd1, 32'd0, 32'd4,  32'd0, 1'b1};
        vecs[1] = '{4'hF, 1'b0, 1'b0, 32'd2, 32'd0, 32'd8,  32'd0, 1'b1};
        vecs[2] = '{4'h3, 1'b1, 1'b0, 32'd3, 32'd1, 32'd10, 32'd10, 1'b0};
        vecs[3] = '{4'h1, 1'b1, 1'b0, 32'd4, 32'd2, 32'd11, 32'd1, 1'b0};
        vecs[4] = '{4'hF, 1'b0, 1'b0, 32'd5, 32'd2, 32'd15, 32'd1, 1'b1};
        vecs[5] = '{4'h7, 1'b1, 1'b1, 32'd1, 32'd1, 32'd3,  32'd7, 1'b0};
        vecs[6] = '{4'h5, 1'b0, 1'b0, 32'd2, 32'd1, 32'd5,  32'd7, 1'b1};
        vecs[7] = '{4'h0, 1'b0, 1'b0, 32'd3, 32'd1, 32'd5,  32'd7, 1'b1};
        vecs[8] = '{4'h8, 1'b1, 1'b0, 32'd4, 32'd2, 32'd6,  32'd3, 1'b0};

        rstn = 1'b0; clear = 1'b0; throttle = 8'h00; t_valid = 1'b0; t_last = 1'b0;
        t_data = '0; t_keep = '0; t_strb = '0; t_id = 4'h2; t_dest = 4'h5; t_user = 1'b0;

        repeat (3) step();
        check("rst.ready", 32'(ch32.t_ready), 32'd0);
        check("rst.beat",  beat32, 32'd0);
        check("rst.pkt",   pkt32,  32'd0);
        check("rst.bytes", bytes32, 32'd0);
        check("rst.lpb",   lpb32,  32'd0);
        check("rst.inp",   32'(inp32), 32'd0);
        check("rst.perr",  32'(perr32), 32'd0);
        rstn = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("ready_after_rst%0d", i), 32'(ch32.t_ready), 32'd1);
            step();
        end

        for (int i = 0; i < 9; i++)
            send($sformatf("vec%0d", i), vecs[i].keep, vecs[i].last, vecs[i].clr,
                 vecs[i].beat, vecs[i].pkt, vecs[i].bytes, vecs[i].lpb, vecs[i].inp);

        // Clear with no handshake mid-packet keeps the accumulator and FSM.
        send("open", 4'hF, 1'b0, 1'b0, 32'd5, 32'd2, 32'd10, 32'd3, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr.beat",  beat32, 32'd0);
        check("clr.pkt",   pkt32,  32'd0);
        check("clr.bytes", bytes32, 32'd0);
        check("clr.lpb",   lpb32,  32'd0);
        check("clr.inp",   32'(inp32), 32'd1);
        send("close", 4'h1, 1'b1, 1'b0, 32'd1, 32'd1, 32'd1, 32'd5, 1'b0);

        // Reset mid-packet discards the partial packet.
        send("partial", 4'hF, 1'b0, 1'b0, 32'd2, 32'd1, 32'd5, 32'd5, 1'b1);
        do_reset();
        check("midrst.inp",  32'(inp32), 32'd0);
        check("midrst.beat", beat32, 32'd0);
        send("fresh", 4'h3, 1'b1, 1'b0, 32'd1, 32'd1, 32'd2, 32'd2, 1'b0);

        // Narrow counters wrap modulo 16.
        do_reset();
        for (int i = 0; i < 17; i++)
            send($sformatf("wrap%0d", i), 4'h1, 1'b1, 1'b0, 32'(i + 1), 32'(i + 1), 32'(i + 1), 32'd1, 1'b0);
        check("wrap4.beat",  32'(beat4),  32'd1);
        check("wrap4.pkt",   32'(pkt4),   32'd1);
        check("wrap4.bytes", 32'(bytes4), 32'd1);
        check("wrap4.lpb",   32'(lpb4),   32'd1);

        // Beat offered while t_ready is still low right after reset, then held stable.
        rstn = 1'b0; t_valid = 1'b1; t_data = 32'hDEAD_BEEF; t_keep = 4'hF; t_strb = 4'hF; t_last = 1'b1;
        repeat (2) step();
        rstn = 1'b1;
        step();
        check("hold.perr0", 32'(perr32), 32'd0);
        step();
        t_valid = 1'b0;
        check("hold.perr1", 32'(perr32), 32'd0);
        check("hold.beat",  beat32, 32'd1);

        // Same stall, but valid is dropped.
        rstn = 1'b0; t_valid = 1'b1;
        repeat (2) step();
        rstn = 1'b1;
        step();
        t_valid = 1'b0;
        step();
        check("drop.perr", 32'(perr32), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("drop.perr_after_clear", 32'(perr32), 32'd1);
        check("drop.beat_after_clear", beat32, 32'd0);

        // Same stall, but data changes.
        rstn = 1'b0; t_valid = 1'b1;
        repeat (2) step();
        check("chg.perr_rst", 32'(perr32), 32'd0);
        rstn = 1'b1;
        step();
        t_data = t_data ^ 32'h1;
        step();
        t_valid = 1'b0;
        check("chg.perr", 32'(perr32), 32'd1);

`ifdef STREAM_COUNTING_SINK_THROTTLE_EN
        throttle = 8'h80;
        do_reset();
        for (int i = 0; i < 1000; i++) begin rec1[i] = ch32.t_ready; step(); end
        do_reset();
        for (int i = 0; i < 1000; i++) begin rec2[i] = ch32.t_ready; step(); end
        ones = 0; diffs = 0;
        for (int i = 0; i < 1000; i++) begin
            ones += int'(rec1[i]);
            if (rec1[i] !== rec2[i]) diffs++;
        end
        check("thr.half",   32'(ones >= 400 && ones <= 600), 32'd1);
        check("thr.repeat", 32'(diffs), 32'd0);
        do_reset();
        for (int i = 0; i < 500; i++)
            send($sformatf("thr%0d", i), 4'hF, 1'b1, 1'b0, 32'(i + 1), 32'(i + 1), 32'(4 * (i + 1)), 32'd4, 1'b0);

        throttle = 8'hFF;
        do_reset();
        for (int n = 0; n < 1000 && ch32.t_ready; n++) step();
        check("ff.ready_low", 32'(ch32.t_ready), 32'd0);
        t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        step();
        check("ff.perr", 32'(perr32), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("ff.perr_after_clear", 32'(perr32), 32'd1);
        throttle = 8'h00;
`endif

        do_reset();
        check("final.perr_cleared", 32'(perr32), 32'd0);
        check("final.sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_counting_sink.md
# stream_counting_sink

AXI-Stream terminal consumer for bring-up and benchmarking: sits at the downstream end of a `stream_channel`, accepts every word, and counts beats, packets and bytes. It also reports the byte length of the most recent packet and flags upstream protocol violations. An optional pseudo-random back-pressure generator exercises upstream stall handling.

## Interface
- `COUNT_WIDTH`, 32: width of all statistics counters.
- `clk`  in  1: clock; all logic on rising edge.
- `rstn`  in  1: synchronous, active-low reset.
- `master`  `stream_channel.slave`  —: input stream. Sink drives `t_ready` only. `t_keep` width is `DATA_WIDTH/8` of the channel.
- `clear`  in  1: synchronous zeroing of statistics counters.
- `throttle`  in  8: back-pressure threshold; ignored unless throttling is compiled in.
- `beat_count`  out  `COUNT_WIDTH`: accepted beats.
- `packet_count`  out  `COUNT_WIDTH`: accepted beats with `t_last=1`.
- `byte_count`  out  `COUNT_WIDTH`: sum of popcount(`t_keep`) over accepted beats.
- `last_packet_bytes`  out  `COUNT_WIDTH`: byte total of the most recently completed packet.
- `in_packet`  out  1: high between the first beat and the last beat of a packet.
- `protocol_error`  out  1: sticky violation flag.

## Operation
- Handshake: a beat is accepted when `t_valid && t_ready` at a rising edge.
- Reset: all counters, `last_packet_bytes`, the packet accumulator, `in_packet` and `protocol_error` go to 0. `t_ready` goes to 0. FSM enters IDLE.
- FSM:
  - IDLE: accepted beat with `t_last=0` moves to IN_PACKET. Accepted beat with `t_last=1` is a single-beat packet and stays in IDLE.
  - IN_PACKET: accepted beat with `t_last=1` moves to IDLE.
  - `in_packet` is 1 exactly when the FSM is in IN_PACKET.
- Accumulator:
  - IDLE beat: `acc = popcount(t_keep)`.
  - IN_PACKET beat: `acc += popcount(t_keep)`.
  - On a `t_last` beat, `last_packet_bytes = acc_before + popcount(t_keep)`, where `acc_before` is 0 in IDLE.
- Counters wrap modulo 2^`COUNT_WIDTH`; there is no saturation.
- `clear` zeroes `beat_count`, `packet_count`, `byte_count` and `last_packet_bytes`. It does not touch the FSM, the accumulator or `protocol_error`.
- Clear with a simultaneous handshake: `next = 0 + increment`, so the coincident beat is counted.
  - Same rule for `last_packet_bytes`: if that beat has `t_last=1`, it takes the new packet total.
- `protocol_error` sets (and only `rstn` clears it) when, on the cycle after `t_valid=1 && t_ready=0`, either:
  - `t_valid` is 0, or
  - any of `t_data`, `t_keep`, `t_strb`, `t_last`, `t_id`, `t_dest`, `t_user` differs from its registered value.
- `t_strb` is not used for byte counting.

## Timing
- `t_ready` is registered.
  - Without throttle: first cycle after `rstn` rises, `t_ready=1`, then constant.
  - With throttle: pattern given under Configuration.
- All statistics outputs are registered. They reflect a beat accepted at edge N from edge N onward (visible in cycle N+1); there is no additional latency.
- `in_packet` and `protocol_error` update on the same edge as the triggering event.
- `rstn` low mid-packet: the partial packet is discarded. The next beat after reset is treated as a packet start.

## Configuration
- `STREAM_COUNTING_SINK_THROTTLE_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is seeded to 16'hACE1 on reset and advances every cycle.
  - Registered `t_ready <= (lfsr[7:0] >= throttle)`.
  - `throttle=0` gives always-ready from the first cycle after reset.
- Not defined: no LFSR; `throttle` is unused; `t_ready` follows the always-ready rule.

## Structure
- Package `stream_counting_sink_pkg` holds:
  - the FSM state enum `{IDLE, IN_PACKET}`;
  - `LFSR_SEED=16'hACE1`;
  - `LFSR_TAPS=16'hB400`.
- Sub-module `stream_lfsr` (parameterised width, taps and seed; outputs the current state) is instantiated only under the macro.
- Popcount is a package function parameterised by `t_keep` width.

## Test plan
- Reset, then 3-beat packet (`t_keep` 4'hF, 4'hF, 4'h3, last on beat 3), no throttle macro -> `beat_count=3`, `packet_count=1`, `byte_count=10`, `last_packet_bytes=10`; `in_packet` high after beats 1–2, low after beat 3.
- Single-beat packet with `t_keep=4'h1`, last=1, issued from IDLE -> `packet_count+1`, `last_packet_bytes=1`, `in_packet` stays 0.
- `clear` asserted on the same edge as an accepted last beat with `t_keep=4'h7` -> `beat_count=1`, `packet_count=1`, `byte_count=3`, `last_packet_bytes` = full packet total.
- `COUNT_WIDTH=4`, 17 accepted single-beat packets -> `beat_count=1`, `packet_count=1` (wrap).
- Upstream drops `t_valid` while `t_ready=0` (throttle macro, `throttle=8'hFF`) -> `protocol_error=1` the next cycle, and it remains set after `clear`.
- Throttle macro with `throttle=0` -> `t_ready=1` every cycle after reset. With `throttle=8'h80`, over 1000 cycles `t_ready` is high roughly half of cycles, the sequence repeats identically after re-reset, and all 500 offered beats are eventually counted.
